// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving the icache refill path and the dcache refill/writeback
// path turns on one external memory port, with fixed-length line bursts.
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int BEATS  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ic_req,
   input  logic [ADDR_W-1:0] ic_addr,
   output logic [DATA_W-1:0] ic_rdata,
   output logic              ic_rvalid,
   output logic              ic_done,
   input  logic              dc_req,
   input  logic              dc_we,
   input  logic [ADDR_W-1:0] dc_addr,
   input  logic [DATA_W-1:0] dc_wdata,
   output logic              dc_wready,
   output logic [DATA_W-1:0] dc_rdata,
   output logic              dc_rvalid,
   output logic              dc_done,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int LOW_W = CNT_W + 2;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
   localparam logic LG_IC = 1'b0;
   localparam logic LG_DC = 1'b1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IC_XFER = 2'd1,
      DC_XFER = 2'd2
   } state_t;

   state_t            state_r, state_s;
   logic [CNT_W-1:0]  cnt_r, cnt_s;
   logic [ADDR_W-1:0] base_r, base_s;
   logic              we_r, we_s;
   logic              last_grant_r, last_grant_s;
   logic              ic_own_s, dc_own_s, last_s;

   // Bursts always start on the line boundary, never at the miss word.
   function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
      line_base = addr & {{(ADDR_W-LOW_W){1'b1}}, {LOW_W{1'b0}}};
   endfunction

   // Arbitration in IDLE and beat sequencing during a burst.
   always_comb begin
      state_s      = state_r;
      cnt_s        = cnt_r;
      base_s       = base_r;
      we_s         = we_r;
      last_grant_s = last_grant_r;
      case (state_r)
         IDLE: begin
            if (ic_req && (!dc_req || (last_grant_r == LG_DC))) begin
               state_s      = IC_XFER;
               cnt_s        = {CNT_W{1'b0}};
               base_s       = line_base(ic_addr);
               we_s         = 1'b0;
               last_grant_s = LG_IC;
            end else if (dc_req) begin
               state_s      = DC_XFER;
               cnt_s        = {CNT_W{1'b0}};
               base_s       = line_base(dc_addr);
               we_s         = dc_we;
               last_grant_s = LG_DC;
            end else begin
               state_s = IDLE;
            end
         end
         IC_XFER, DC_XFER: begin
            if (mem_ack) begin
               if (cnt_r == LAST_BEAT) begin
                  state_s = IDLE;
                  cnt_s   = {CNT_W{1'b0}};
               end else begin
                  cnt_s = cnt_r + CNT_W'(1);
               end
            end else begin
               cnt_s = cnt_r;
            end
         end
         default: begin
            state_s = IDLE;
            cnt_s   = {CNT_W{1'b0}};
         end
      endcase
   end

   // Arbiter state registers; reset aborts any burst in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         cnt_r        <= {CNT_W{1'b0}};
         base_r       <= {ADDR_W{1'b0}};
         we_r         <= 1'b0;
         last_grant_r <= LG_IC;
      end else begin
         state_r      <= state_s;
         cnt_r        <= cnt_s;
         base_r       <= base_s;
         we_r         <= we_s;
         last_grant_r <= last_grant_s;
      end
   end

   // Port outputs decode from the state registers; beat handshakes pass mem_ack straight through.
   always_comb begin
      ic_own_s = (state_r == IC_XFER);
      dc_own_s = (state_r == DC_XFER);
      last_s   = (cnt_r == LAST_BEAT);
      mem_req  = ic_own_s | dc_own_s;
      mem_we   = dc_own_s & we_r;
      if (mem_req) begin
         mem_addr = base_r + ADDR_W'({cnt_r, 2'b00});
      end else begin
         mem_addr = {ADDR_W{1'b0}};
      end
      if (mem_we) begin
         mem_wdata = dc_wdata;
      end else begin
         mem_wdata = {DATA_W{1'b0}};
      end
      if (ic_own_s) begin
         ic_rdata = mem_rdata;
      end else begin
         ic_rdata = {DATA_W{1'b0}};
      end
      if (dc_own_s && !we_r) begin
         dc_rdata = mem_rdata;
      end else begin
         dc_rdata = {DATA_W{1'b0}};
      end
      ic_rvalid = ic_own_s & mem_ack;
      ic_done   = ic_own_s & mem_ack & last_s;
      dc_rvalid = dc_own_s & ~we_r & mem_ack;
      dc_wready = dc_own_s & we_r & mem_ack;
      dc_done   = dc_own_s & mem_ack & last_s;
   end

endmodule
